// File: rtl/fma16_pkg.sv
// Shared constants for the fp16 FMA sequencer: one-hot state codes, rounding modes,
// flag bit positions and the first-stage selection used on operation accept.
package fma16_pkg;

  typedef logic [5:0] state_t;

  localparam state_t ST_IDLE = 6'b000001;
  localparam state_t ST_MUL  = 6'b000010;
  localparam state_t ST_ADD  = 6'b000100;
  localparam state_t ST_NORM = 6'b001000;
  localparam state_t ST_RND  = 6'b010000;
  localparam state_t ST_HOLD = 6'b100000;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RM  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Skipped stages fall through to the next one that is requested.
  function automatic state_t first_stage(input logic mul, input logic add);
    state_t st;
    if (mul) begin
      st = ST_MUL;
    end else if (add) begin
      st = ST_ADD;
    end else begin
      st = ST_NORM;
    end
    return st;
  endfunction

endpackage

// File: rtl/fma16_seq_ctrl_if.sv
// Operation request and result handshake bundle between a requester and the FMA sequencer.
interface fma16_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;
  logic        in_mul;
  logic        in_add;
  logic        in_negp;
  logic        in_negz;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_x, in_y, in_z, in_mul, in_add, in_negp, in_negz, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_mul, in_add, in_negp, in_negz, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fma16_csr.sv
// Rounding-mode CSR and sticky exception-flag CSR; a clear and a capture on the same
// edge keep the newly captured flags.
module fma16_csr
  import fma16_pkg::*;
#(
  parameter logic [1:0] RM_RESET = RM_RNE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [1:0] cfg_rm,
  input  logic       cfg_clr_flags,
  input  logic       cap_en,
  input  logic [3:0] cap_flags,
  output logic [1:0] rm_q,
  output logic [3:0] flags_q
);

  logic [3:0] flags_next_s;

  // Clear first, then OR in the flags of a retiring operation.
  always_comb begin
    flags_next_s = 4'b0000;
    if (cfg_clr_flags) begin
      flags_next_s = 4'b0000;
    end else begin
      flags_next_s = flags_q;
    end
    if (cap_en) begin
      flags_next_s = flags_next_s | cap_flags;
    end else begin
      flags_next_s = flags_next_s;
    end
  end

  // CSR storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rm_q    <= RM_RESET;
      flags_q <= 4'b0000;
    end else begin
      if (cfg_we) begin
        rm_q <= cfg_rm;
      end
      flags_q <= flags_next_s;
    end
  end

endmodule

// File: rtl/fma16_seq_ctrl.sv
// Multi-cycle sequencer for the fp16 FMA datapath: accepts one op, walks the
// MUL/ADD/NORM/RND stage enables, then holds the result until it is taken.
module fma16_seq_ctrl
  import fma16_pkg::*;
#(
  parameter int         ADD_CYCLES = 1,
  parameter logic [1:0] RM_RESET   = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  fma16_seq_ctrl_if.slave  io,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_rm,
  input  logic             cfg_clr_flags,
  output logic [1:0]       rm_q,
  output logic [3:0]       flags_q,
  output logic [15:0]      dp_x,
  output logic [15:0]      dp_y,
  output logic [15:0]      dp_z,
  output logic             dp_mul,
  output logic             dp_add,
  output logic             dp_negp,
  output logic             dp_negz,
  output logic [1:0]       dp_rm,
  output logic             dp_en_mul,
  output logic             dp_en_add,
  output logic             dp_en_norm,
  output logic             dp_en_rnd,
  input  logic [15:0]      dp_result,
  input  logic [3:0]       dp_flags,
  output logic             busy
);

  localparam logic [2:0] ADD_LOAD = 3'(ADD_CYCLES - 1);

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] add_cnt_r;
  logic       accept_s;

  assign io.in_ready = (state_r == ST_IDLE) | ((state_r == ST_HOLD) & io.out_ready);
  assign accept_s    = io.in_valid & io.in_ready;
  assign dp_en_mul   = (state_r == ST_MUL);
  assign dp_en_add   = (state_r == ST_ADD);
  assign dp_en_norm  = (state_r == ST_NORM);
  assign dp_en_rnd   = (state_r == ST_RND);
  assign busy        = (state_r != ST_IDLE);

  // Stage sequencing; HOLD can retire and accept on the same edge.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = first_stage(io.in_mul, io.in_add);
        else          next_state_s = ST_IDLE;
      end
      ST_MUL: begin
        if (dp_add) next_state_s = ST_ADD;
        else        next_state_s = ST_NORM;
      end
      ST_ADD: begin
        if (add_cnt_r == 3'd0) next_state_s = ST_NORM;
        else                   next_state_s = ST_ADD;
      end
      ST_NORM: next_state_s = ST_RND;
      ST_RND:  next_state_s = ST_HOLD;
      ST_HOLD: begin
        if (!io.out_ready)  next_state_s = ST_HOLD;
        else if (accept_s)  next_state_s = first_stage(io.in_mul, io.in_add);
        else                next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and ADD residency down-counter, loaded on entry to ADD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      add_cnt_r <= 3'd0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s == ST_ADD) && (state_r != ST_ADD)) begin
        add_cnt_r <= ADD_LOAD;
      end else if ((state_r == ST_ADD) && (add_cnt_r != 3'd0)) begin
        add_cnt_r <= add_cnt_r - 3'd1;
      end
    end
  end

  // Operand/control latch; the op keeps the rounding mode in force when accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_x    <= 16'h0000;
      dp_y    <= 16'h0000;
      dp_z    <= 16'h0000;
      dp_mul  <= 1'b0;
      dp_add  <= 1'b0;
      dp_negp <= 1'b0;
      dp_negz <= 1'b0;
      dp_rm   <= 2'b00;
    end else if (accept_s) begin
      dp_x    <= io.in_x;
      dp_y    <= io.in_y;
      dp_z    <= io.in_z;
      dp_mul  <= io.in_mul;
      dp_add  <= io.in_add;
      dp_negp <= io.in_negp;
      dp_negz <= io.in_negz;
      dp_rm   <= rm_q;
    end
  end

  // Result register, held stable until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.out_valid  <= 1'b0;
      io.out_result <= 16'h0000;
      io.out_flags  <= 4'b0000;
    end else if (state_r == ST_RND) begin
      io.out_valid  <= 1'b1;
      io.out_result <= dp_result;
      io.out_flags  <= dp_flags;
    end else if ((state_r == ST_HOLD) && io.out_ready) begin
      io.out_valid  <= 1'b0;
    end
  end

  fma16_csr #(.RM_RESET(RM_RESET)) u_csr (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_rm        (cfg_rm),
    .cfg_clr_flags (cfg_clr_flags),
    .cap_en        (state_r == ST_RND),
    .cap_flags     (dp_flags),
    .rm_q          (rm_q),
    .flags_q       (flags_q)
  );

endmodule

// File: tb/tb_fma16_seq_ctrl.sv
// Bench: two sequencers (ADD_CYCLES 1 and 3) share stimulus; a stage-schedule model
// predicts every output each cycle, and directed literals pin latency/results.
module tb_fma16_seq_ctrl;

  localparam int SG_MUL = 0, SG_ADD = 1, SG_NORM = 2, SG_RND = 3;
  localparam int ACYC [2] = '{1, 3};

  logic clk, reset;
  logic in_valid, in_mul, in_add, in_negp, in_negz, out_ready;
  logic [15:0] in_x, in_y, in_z;
  logic cfg_we, cfg_clr_flags;
  logic [1:0] cfg_rm;

  logic o_rdy [2], o_valid [2], o_busy [2];
  logic [15:0] o_result [2];
  logic [3:0] o_flags [2], d_flq [2];
  logic [1:0] d_rmq [2], d_rm [2];
  logic [15:0] d_x [2], d_y [2], d_z [2], d_res [2];
  logic d_mul [2], d_add [2], d_np [2], d_nz [2];
  logic d_en_mul [2], d_en_add [2], d_en_norm [2], d_en_rnd [2];
  logic [3:0] d_flg [2];

  int n_checks = 0, n_err = 0;
  bit chk_on = 0;

  function automatic logic [15:0] stub_res(logic [15:0] x, logic [15:0] y, logic [15:0] z);
    return x ^ y ^ z ^ 16'h0200;
  endfunction
  function automatic logic [3:0] stub_flg(logic np, logic nz, logic [1:0] rm);
    return {np, nz, rm};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fma16_seq_ctrl_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_x      = in_x;
    assign bus.in_y      = in_y;
    assign bus.in_z      = in_z;
    assign bus.in_mul    = in_mul;
    assign bus.in_add    = in_add;
    assign bus.in_negp   = in_negp;
    assign bus.in_negz   = in_negz;
    assign bus.out_ready = out_ready;
    assign o_rdy[g]      = bus.in_ready;
    assign o_valid[g]    = bus.out_valid;
    assign o_result[g]   = bus.out_result;
    assign o_flags[g]    = bus.out_flags;
    assign d_res[g] = d_en_rnd[g] ? stub_res(d_x[g], d_y[g], d_z[g]) : 16'h0000;
    assign d_flg[g] = d_en_rnd[g] ? stub_flg(d_np[g], d_nz[g], d_rm[g]) : 4'h0;

    fma16_seq_ctrl #(.ADD_CYCLES((g == 0) ? 1 : 3), .RM_RESET(2'b01)) dut (
      .clk(clk), .reset(reset), .io(bus),
      .cfg_we(cfg_we), .cfg_rm(cfg_rm), .cfg_clr_flags(cfg_clr_flags),
      .rm_q(d_rmq[g]), .flags_q(d_flq[g]),
      .dp_x(d_x[g]), .dp_y(d_y[g]), .dp_z(d_z[g]),
      .dp_mul(d_mul[g]), .dp_add(d_add[g]), .dp_negp(d_np[g]), .dp_negz(d_nz[g]),
      .dp_rm(d_rm[g]),
      .dp_en_mul(d_en_mul[g]), .dp_en_add(d_en_add[g]),
      .dp_en_norm(d_en_norm[g]), .dp_en_rnd(d_en_rnd[g]),
      .dp_result(d_res[g]), .dp_flags(d_flg[g]), .busy(o_busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, got, exp);
    end
  endtask

  // ---------------- model: a schedule of remaining stages per op ----------------
  int sched [2][16];
  int slen [2];
  bit hold_m [2], ov_m [2];
  logic [15:0] res_m [2], lx [2], ly [2], lz [2];
  logic [3:0] of_m [2], fl_m [2];
  logic lmul [2], ladd [2], lnp [2], lnz [2];
  logic [1:0] lrm [2], rm_m [2];

  task automatic push(input int i, input int s);
    sched[i][slen[i]] = s;
    slen[i]++;
  endtask

  task automatic model_step(input int i);
    bit rdy, acc, rnd;
    logic [1:0] old_rm;
    if (reset) begin
      slen[i] = 0; hold_m[i] = 0; ov_m[i] = 0; res_m[i] = 16'h0; of_m[i] = 4'h0;
      fl_m[i] = 4'h0; rm_m[i] = 2'b01; lx[i] = 16'h0; ly[i] = 16'h0; lz[i] = 16'h0;
      lmul[i] = 0; ladd[i] = 0; lnp[i] = 0; lnz[i] = 0; lrm[i] = 2'b00;
      return;
    end
    rdy = (slen[i] == 0 && !hold_m[i]) || (hold_m[i] && out_ready);
    acc = in_valid && rdy;
    rnd = (slen[i] > 0) && (sched[i][0] == SG_RND);
    old_rm = rm_m[i];
    fl_m[i] = (cfg_clr_flags ? 4'h0 : fl_m[i]) | (rnd ? stub_flg(lnp[i], lnz[i], lrm[i]) : 4'h0);
    if (cfg_we) rm_m[i] = cfg_rm;
    if (rnd) begin
      ov_m[i] = 1; hold_m[i] = 1;
      res_m[i] = stub_res(lx[i], ly[i], lz[i]);
      of_m[i] = stub_flg(lnp[i], lnz[i], lrm[i]);
    end else if (hold_m[i] && out_ready) begin
      ov_m[i] = 0; hold_m[i] = 0;
    end
    if (slen[i] > 0) begin
      for (int j = 0; j < 15; j++) sched[i][j] = sched[i][j+1];
      slen[i]--;
    end
    if (acc) begin
      lx[i] = in_x; ly[i] = in_y; lz[i] = in_z; lmul[i] = in_mul; ladd[i] = in_add;
      lnp[i] = in_negp; lnz[i] = in_negz; lrm[i] = old_rm;
      if (in_mul) push(i, SG_MUL);
      if (in_add) for (int j = 0; j < ACYC[i]; j++) push(i, SG_ADD);
      push(i, SG_NORM);
      push(i, SG_RND);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic bit stage_is(int i, int s);
    return (slen[i] > 0) && (sched[i][0] == s);
  endfunction

  // Every cycle, outside reset: all DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      for (int i = 0; i < 2; i++) begin
        bit bz;
        bz = (slen[i] > 0) || hold_m[i];
        chk("busy", i, 32'(o_busy[i]), 32'(bz));
        chk("in_ready", i, 32'(o_rdy[i]), 32'(!bz || (hold_m[i] && out_ready)));
        chk("en_mul", i, 32'(d_en_mul[i]), 32'(stage_is(i, SG_MUL)));
        chk("en_add", i, 32'(d_en_add[i]), 32'(stage_is(i, SG_ADD)));
        chk("en_norm", i, 32'(d_en_norm[i]), 32'(stage_is(i, SG_NORM)));
        chk("en_rnd", i, 32'(d_en_rnd[i]), 32'(stage_is(i, SG_RND)));
        chk("out_valid", i, 32'(o_valid[i]), 32'(ov_m[i]));
        chk("out_result", i, 32'(o_result[i]), 32'(res_m[i]));
        chk("out_flags", i, 32'(o_flags[i]), 32'(of_m[i]));
        chk("rm_q", i, 32'(d_rmq[i]), 32'(rm_m[i]));
        chk("flags_q", i, 32'(d_flq[i]), 32'(fl_m[i]));
        chk("dp_xyz", i, {d_x[i], d_y[i] ^ d_z[i]}, {lx[i], ly[i] ^ lz[i]});
        chk("dp_z", i, 32'(d_z[i]), 32'(lz[i]));
        chk("dp_ctl", i, 32'({d_mul[i], d_add[i], d_np[i], d_nz[i], d_rm[i]}),
            32'({lmul[i], ladd[i], lnp[i], lnz[i], lrm[i]}));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int r_lat [2], r_nadd [2], r_nmul [2];
  logic [15:0] r_res [2];
  logic [3:0] r_flg [2];

  task automatic wait_idle();
    int t = 0;
    while ((o_busy[0] || o_busy[1]) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", 0, 32'(t < 50), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, y, z, input logic mul, add, np, nz,
                        input int cfg_cyc, input bit clr_on_rnd);
    wait_idle();
    out_ready = 1; in_valid = 1; in_x = x; in_y = y; in_z = z;
    in_mul = mul; in_add = add; in_negp = np; in_negz = nz;
    @(posedge clk); #1;
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      r_lat[i] = -1; r_nadd[i] = 0; r_nmul[i] = 0; r_res[i] = 16'h0; r_flg[i] = 4'h0;
    end
    for (int k = 1; k <= 10; k++) begin
      cfg_we = (k == cfg_cyc);
      cfg_rm = 2'b11;
      cfg_clr_flags = clr_on_rnd && d_en_rnd[0];
      for (int i = 0; i < 2; i++) begin
        r_nadd[i] += int'(d_en_add[i]);
        r_nmul[i] += int'(d_en_mul[i]);
      end
      @(posedge clk); #1;
      cfg_we = 0; cfg_clr_flags = 0;
      for (int i = 0; i < 2; i++) begin
        if (r_lat[i] < 0 && o_valid[i]) begin
          r_lat[i] = k; r_res[i] = o_result[i]; r_flg[i] = o_flags[i];
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv [2];
    reset = 1; in_valid = 0; in_x = 16'h0; in_y = 16'h0; in_z = 16'h0;
    in_mul = 0; in_add = 0; in_negp = 0; in_negz = 0; out_ready = 1;
    cfg_we = 0; cfg_rm = 2'b00; cfg_clr_flags = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0; chk_on = 1;
    chk("rst_rm", 0, 32'(d_rmq[0]), 32'h1);
    chk("rst_flags", 0, 32'(d_flq[0]), 32'h0);
    chk("rst_valid", 1, 32'(o_valid[1]), 32'h0);
    chk("rst_dpx", 0, 32'(d_x[0]), 32'h0);

    // Full op
    run_op(16'h3C00, 16'h4000, 16'h3C00, 1, 1, 0, 0, 0, 0);
    chk("lat_full", 0, r_lat[0], 4);
    chk("lat_full", 1, r_lat[1], 6);
    chk("res_full", 0, 32'(r_res[0]), 32'h4200);
    chk("nadd_full", 1, r_nadd[1], 3);
    chk("nmul_full", 0, r_nmul[0], 1);
    chk("flags_full", 0, 32'(d_flq[0]), 32'h1);
    chk("dprm_full", 0, 32'(d_rm[0]), 32'h1);

    // MUL skipped
    run_op(16'h4400, 16'h3800, 16'h0000, 0, 1, 0, 0, 0, 0);
    chk("lat_nomul", 0, r_lat[0], 3);
    chk("lat_nomul", 1, r_lat[1], 5);
    chk("nmul_nomul", 1, r_nmul[1], 0);
    chk("res_nomul", 1, 32'(r_res[1]), 32'h7E00);

    // ADD skipped, product negated
    run_op(16'h1234, 16'h5678, 16'h9ABC, 1, 0, 1, 0, 0, 0);
    chk("lat_noadd", 1, r_lat[1], 3);
    chk("res_noadd", 0, 32'(r_res[0]), 32'hDCF0);
    chk("flags_acc", 0, 32'(d_flq[0]), 32'h9);

    // Both skipped; clear on the RND edge keeps only the new flags
    run_op(16'hAAAA, 16'h5555, 16'h0F0F, 0, 0, 0, 0, 0, 1);
    chk("lat_none", 0, r_lat[0], 2);
    chk("res_none", 0, 32'(r_res[0]), 32'hF2F0);
    chk("clr_rnd", 0, 32'(d_flq[0]), 32'h1);

    // Rounding mode written mid-op
    run_op(16'h3C00, 16'h4000, 16'h3C00, 1, 1, 0, 0, 2, 0);
    chk("rm_inflight", 0, 32'(r_flg[0]), 32'h1);
    chk("rm_new", 0, 32'(d_rmq[0]), 32'h3);
    run_op(16'h3C00, 16'h4000, 16'h3C00, 1, 1, 0, 0, 0, 0);
    chk("rm_nextop", 1, 32'(d_rm[1]), 32'h3);
    chk("rm_nextflg", 0, 32'(r_flg[0]), 32'h3);

    // Backpressure, then retire+accept on one edge
    wait_idle();
    out_ready = 0; in_valid = 1; in_x = 16'h1111; in_y = 16'h2222; in_z = 16'h4444;
    in_mul = 1; in_add = 1; in_negp = 0; in_negz = 0;
    @(posedge clk); #1 in_valid = 0;
    begin
      int t = 0;
      while (!(o_valid[0] && o_valid[1]) && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("hold_timeout", 0, 32'(t < 20), 32'd1);
    end
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", 0, 32'(o_valid[0]), 32'h1);
      chk("hold_res", 0, 32'(o_result[0]), 32'h7577);
      chk("hold_rdy", 1, 32'(o_rdy[1]), 32'h0);
    end
    out_ready = 1; in_valid = 1; in_x = 16'h0100; in_y = 16'h0200; in_z = 16'h0400;
    in_mul = 0; in_add = 0;
    @(posedge clk); #1 in_valid = 0;
    chk("b2b_valid", 0, 32'(o_valid[0]), 32'h0);
    chk("b2b_busy", 1, 32'(o_busy[1]), 32'h1);
    chk("b2b_dpx", 1, 32'(d_x[1]), 32'h0100);

    // Reset during ADD
    wait_idle();
    in_valid = 1; in_x = 16'h3C00; in_y = 16'h4000; in_z = 16'h3C00; in_mul = 1; in_add = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
    chk("in_add", 0, 32'(d_en_add[0]), 32'h1);
    reset = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mrst_valid", i, 32'(o_valid[i]), 32'h0);
      chk("mrst_busy", i, 32'(o_busy[i]), 32'h0);
      chk("mrst_rm", i, 32'(d_rmq[i]), 32'h1);
      chk("mrst_flags", i, 32'(d_flq[i]), 32'h0);
    end
    @(posedge clk); #1 reset = 0;
    nv = '{0, 0};
    repeat (12) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) nv[i] += int'(o_valid[i]);
    end
    chk("mrst_noout", 0, nv[0], 0);
    chk("mrst_noout", 1, nv[1], 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
